// File: rtl/piso_serializer_if.sv
// Word handshake between a transmit source and the piso_serializer.
// The source drives master, the serializer consumes through slave.
interface piso_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial transmitter with an sh strobe for a SIPO receiver.
// Define PISO_SERIALIZER_PARITY_EN to append a parity bit after the data bits.
module piso_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_PERIOD = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_serializer_if.slave s_if,
    output logic             sd,
    output logic             sh,
    output logic             busy,
    output logic             done
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int NBITS = DATA_WIDTH + 1;
`else
    localparam int NBITS = DATA_WIDTH;
`endif
    localparam int DIV_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int BIT_W = $clog2(NBITS);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(BIT_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_RELOAD = BIT_W'(NBITS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [NBITS-1:0]   sreg_reg, sreg_next;
    logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
    logic               sd_reg, sd_next;
    logic               sh_reg, sh_next;
    logic               done_reg, done_next;
    logic [NBITS-1:0]   load_word;
    logic [NBITS-1:0]   sreg_shl;

`ifdef PISO_SERIALIZER_PARITY_EN
    assign load_word = {s_if.s_data, (^s_if.s_data) ^ PARITY_ODD};
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign load_word = s_if.s_data;
`endif

    // Left shift with zero fill; the MSB always holds the bit on the wire.
    assign sreg_shl[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NBITS; gi++) begin : g_shl
            assign sreg_shl[gi] = sreg_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sreg_reg    <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            sd_reg      <= 1'b0;
            sh_reg      <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sreg_reg    <= sreg_next;
            bit_cnt_reg <= bit_cnt_next;
            div_cnt_reg <= div_cnt_next;
            sd_reg      <= sd_next;
            sh_reg      <= sh_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sreg_next    = sreg_reg;
        bit_cnt_next = bit_cnt_reg;
        div_cnt_next = div_cnt_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (s_if.s_valid) begin
                    sreg_next    = load_word;
                    bit_cnt_next = BIT_RELOAD;
                    div_cnt_next = DIV_RELOAD;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt_reg != '0) begin
                    div_cnt_next = div_cnt_reg - 1'b1;
                end else begin
                    div_cnt_next = DIV_RELOAD;
                    sreg_next    = sreg_shl;
                    if (bit_cnt_reg != '0) begin
                        bit_cnt_next = bit_cnt_reg - 1'b1;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Serial outputs are registered from the next state so they align with it.
        sd_next = (state_next == SHIFT) ? sreg_next[NBITS-1] : 1'b0;
        sh_next = (state_next == SHIFT) && (div_cnt_next == '0);
    end

    assign s_if.s_ready = (state_reg == IDLE);
    assign busy         = (state_reg == SHIFT);
    assign sd           = sd_reg;
    assign sh           = sh_reg;
    assign done         = done_reg;

endmodule
